// File: rtl/receiver_if.sv
// Serial receive bus: line input plus received-byte and status outputs.
// The receiver uses the master view; a byte consumer uses the slave view.
interface receiver_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/receiver.sv
// UART receiver: 8N1 framing, mid-bit sampling, 2-flop input synchronizer.
// Registered data/valid/error pulses and busy flag.
module receiver #(
  parameter int CLOCKS_PER_PULSE = 16
) (
  input  logic        clk,
  input  logic        rstn,
  receiver_if.master  bus
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          err_q;
  logic          busy_q;
  logic          meta_q;
  logic          rx_s_q;
  logic          armed_q;

  assign shift_d = {rx_s_q, shift_q[7:1]};

  // armed_q blocks a held-low line (break) from retriggering a frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      meta_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      meta_q  <= bus.rx;
      rx_s_q  <= meta_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= cnt_q + 1'b1;
      unique case (state_q)
        RX_IDLE: begin
          if (rx_s_q) armed_q <= 1'b1;
          if (!rx_s_q && armed_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= RX_DATA;
              bit_idx_q <= '0;
            end
          end
        end
        RX_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q     <= '0;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            busy_q  <= 1'b0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q   <= 1'b1;
              armed_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.rx_busy    = busy_q;

endmodule
